// File: rtl/fft_unload.sv
// Ping-pong unload buffer: takes 8-point bit-reversed FFT frames in parallel and emits them serially in natural order.
// Optional FFT_UNLOAD_SCALE_EN divides each output sample by 8 (arithmetic shift right 3).
module fft_unload #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2**N-1:0]   xr0,
  input  logic [2**N-1:0]   xr1,
  input  logic [2**N-1:0]   xr2,
  input  logic [2**N-1:0]   xr3,
  input  logic [2**N-1:0]   xr4,
  input  logic [2**N-1:0]   xr5,
  input  logic [2**N-1:0]   xr6,
  input  logic [2**N-1:0]   xr7,
  input  logic [2**N-1:0]   xi0,
  input  logic [2**N-1:0]   xi1,
  input  logic [2**N-1:0]   xi2,
  input  logic [2**N-1:0]   xi3,
  input  logic [2**N-1:0]   xi4,
  input  logic [2**N-1:0]   xi5,
  input  logic [2**N-1:0]   xi6,
  input  logic [2**N-1:0]   xi7,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2**N-1:0]   out_re,
  output logic [2**N-1:0]   out_im,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int W = 2**N;

  logic [W-1:0] in_re [8];
  logic [W-1:0] in_im [8];

  logic [W-1:0] re_q [2][8];
  logic [W-1:0] re_d [2][8];
  logic [W-1:0] im_q [2][8];
  logic [W-1:0] im_d [2][8];
  logic [1:0]   full_q, full_d;
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         in_ready_q, in_ready_d;

  logic         accept, rd_hs, rd_done;
  logic [2:0]   rd_loc;
  logic [W-1:0] raw_re, raw_im;

  always_comb begin
    in_re[0] = xr0; in_re[1] = xr1; in_re[2] = xr2; in_re[3] = xr3;
    in_re[4] = xr4; in_re[5] = xr5; in_re[6] = xr6; in_re[7] = xr7;
    in_im[0] = xi0; in_im[1] = xi1; in_im[2] = xi2; in_im[3] = xi3;
    in_im[4] = xi4; in_im[5] = xi5; in_im[6] = xi6; in_im[7] = xi7;
  end

  assign out_valid = full_q[rptr_q];
  assign accept    = in_valid & in_ready_q;
  assign rd_hs     = out_valid & out_ready;
  assign rd_done   = rd_hs & (cnt_q == 3'd7);

  always_comb begin
    re_d       = re_q;
    im_d       = im_q;
    full_d     = full_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    in_ready_d = 1'b0;

    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        re_d[wptr_q][k] = in_re[k];
        im_d[wptr_q][k] = in_im[k];
      end
      wptr_d = ~wptr_q;
    end

    if (rd_hs) begin
      cnt_d = cnt_q + 3'd1;
    end

    // Accept needs an empty write bank and a final read needs a full read bank,
    // so the two updates always target different banks.
    if (rd_done) begin
      full_d[rptr_q] = 1'b0;
      rptr_d         = ~rptr_q;
    end
    if (accept) begin
      full_d[wptr_q] = 1'b1;
    end

    in_ready_d = ~full_d[wptr_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          re_q[b][k] <= '0;
          im_q[b][k] <= '0;
        end
      end
      full_q     <= 2'b00;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 3'd0;
      in_ready_q <= 1'b0;
    end else begin
      re_q       <= re_d;
      im_q       <= im_d;
      full_q     <= full_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Stored frame is in bit-reversed order; reading bitrev(cnt) restores natural order.
  assign rd_loc = {cnt_q[0], cnt_q[1], cnt_q[2]};
  assign raw_re = re_q[rptr_q][rd_loc];
  assign raw_im = im_q[rptr_q][rd_loc];

`ifdef FFT_UNLOAD_SCALE_EN
  assign out_re = $signed(raw_re) >>> 3;
  assign out_im = $signed(raw_im) >>> 3;
`else
  assign out_re = raw_re;
  assign out_im = raw_im;
`endif

  assign in_ready = in_ready_q;
  assign out_idx  = cnt_q;
  assign out_last = out_valid & (cnt_q == 3'd7);

endmodule

// File: tb/tb_fft_unload.sv
// Directed bench for fft_unload: ordering, back-pressure, full banks, streaming, mid-frame reset, scaling.
module tb_fft_unload;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] xr [8];
  logic [15:0] xi [8];
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_re, out_im;
  logic [2:0]  out_idx;
  logic        out_last, out_valid, out_ready;

  int tests_run = 0;
  int fails = 0;

  // Natural bin b lives at stored location br_tab[b].
  localparam int BR_TAB [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  fft_unload #(.N(4)) dut (
    .clk(clk), .rst(rst),
    .xr0(xr[0]), .xr1(xr[1]), .xr2(xr[2]), .xr3(xr[3]),
    .xr4(xr[4]), .xr5(xr[5]), .xr6(xr[6]), .xr7(xr[7]),
    .xi0(xi[0]), .xi1(xi[1]), .xi2(xi[2]), .xi3(xi[3]),
    .xi4(xi[4]), .xi5(xi[5]), .xi6(xi[6]), .xi7(xi[7]),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [15:0] base);
    for (int k = 0; k < 8; k++) begin
      xr[k] = base + 16'(k);
      xi[k] = -16'(k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin xr[k] = '0; xi[k] = '0; end
    tick(); tick();
    tests_run++;
    if ({in_ready, out_valid, out_last, out_idx, out_re, out_im} !== 38'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b idx=%0d re=%h im=%h, want all 0",
               in_ready, out_valid, out_last, out_idx, out_re, out_im);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_rdy_before_edge: got %b want 0", in_ready);
    end
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_rdy_rise: got %b want 1", in_ready);
    end
  endtask

  task automatic test_order();
    logic [15:0] exp_re [8] = '{16'h0100, 16'h0104, 16'h0102, 16'h0106,
                                16'h0101, 16'h0105, 16'h0103, 16'h0107};
    logic [15:0] exp_im [8] = '{16'h0000, 16'hFFFC, 16'hFFFE, 16'hFFFA,
                                16'hFFFF, 16'hFFFB, 16'hFFFD, 16'hFFF9};
    load_frame(16'h0100);
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== 3'(b) || out_re !== exp_re[b] ||
          out_im !== exp_im[b] || out_last !== (b == 7)) begin
        fails++;
        $display("FAIL order_bin%0d: got vld=%b idx=%0d re=%h im=%h last=%b, want 1 %0d %h %h %b",
                 b, out_valid, out_idx, out_re, out_im, out_last, b, exp_re[b], exp_im[b], b == 7);
      end
      tick();
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL order_drained: got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_re [8] = '{16'h0100, 16'h0104, 16'h0102, 16'h0106,
                                16'h0101, 16'h0105, 16'h0103, 16'h0107};
    load_frame(16'h0100);
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== 3'(b) || out_re !== exp_re[b]) begin
        fails++;
        $display("FAIL bp_bin%0d: got vld=%b idx=%0d re=%h, want 1 %0d %h",
                 b, out_valid, out_idx, out_re, b, exp_re[b]);
      end
      if (b == 3) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          tests_run++;
          if (out_valid !== 1'b1 || out_idx !== 3'd3 || out_re !== 16'h0106 ||
              out_im !== 16'hFFFA || out_last !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: got vld=%b idx=%0d re=%h im=%h last=%b, want 1 3 0106 fffa 0",
                     s, out_valid, out_idx, out_re, out_im, out_last);
          end
        end
        out_ready = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_drained: got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      load_frame(16'h0100 * 16'(f + 1));
      in_valid = 1'b1;
      tests_run++;
      if (in_ready !== (f < 2)) begin
        fails++; $display("FAIL full_rdy_frame%0d: got %b want %b", f, in_ready, f < 2);
      end
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL full_rdy_held: got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 8; b++) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_idx !== 3'(b) ||
            out_re !== 16'h0100 * 16'(f + 1) + 16'(BR_TAB[b])) begin
          fails++;
          $display("FAIL full_f%0d_bin%0d: got vld=%b idx=%0d re=%h, want 1 %0d %h", f, b,
                   out_valid, out_idx, out_re, b, 16'h0100 * 16'(f + 1) + 16'(BR_TAB[b]));
        end
        if (f == 0) begin
          tests_run++;
          if (in_ready !== 1'b0) begin
            fails++; $display("FAIL full_rdy_during_read%0d: got %b want 0", b, in_ready);
          end
        end
        tick();
      end
      if (f == 0) begin
        tests_run++;
        if (in_ready !== 1'b1) begin
          fails++; $display("FAIL full_rdy_after_read: got %b want 1", in_ready);
        end
      end
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL full_frame3_dropped: got vld=%b re=%h want vld 0", out_valid, out_re);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c % 8 == 0) begin
        load_frame(16'h1000 * 16'(c / 8 + 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
        fails++; $display("FAIL stream_rdy_c%0d: got %b want 1", c, in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== 3'(c % 8) ||
          out_re !== 16'h1000 * 16'(c / 8 + 1) + 16'(BR_TAB[c % 8])) begin
        fails++;
        $display("FAIL stream_c%0d: got vld=%b idx=%0d re=%h, want 1 %0d %h", c,
                 out_valid, out_idx, out_re, c % 8, 16'h1000 * 16'(c / 8 + 1) + 16'(BR_TAB[c % 8]));
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL stream_drained: got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    load_frame(16'h0100);
    in_valid = 1'b1;
    tick();
    load_frame(16'h0200);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (out_idx !== 3'd4 || out_re !== 16'h0101) begin
      fails++; $display("FAIL rstmid_pre: got idx=%0d re=%h want 4 0101", out_idx, out_re);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, out_valid, out_last, out_idx, out_re, out_im} !== 38'd0) begin
      fails++;
      $display("FAIL rstmid_outputs: got rdy=%b vld=%b last=%b idx=%0d re=%h im=%h, want all 0",
               in_ready, out_valid, out_last, out_idx, out_re, out_im);
    end
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    load_frame(16'h0500);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_re !== 16'h0500) begin
      fails++; $display("FAIL rstmid_new_bin0: got vld=%b idx=%0d re=%h want 1 0 0500",
                        out_valid, out_idx, out_re);
    end
    tick();
    tests_run++;
    if (out_idx !== 3'd1 || out_re !== 16'h0504) begin
      fails++; $display("FAIL rstmid_new_bin1: got idx=%0d re=%h want 1 0504", out_idx, out_re);
    end
    for (int b = 2; b < 8; b++) tick();
    tick();
  endtask

  task automatic test_scale();
    logic [15:0] e0_re, e0_im, e1_re;
`ifdef FFT_UNLOAD_SCALE_EN
    e0_re = 16'hFFFE; e0_im = 16'h0001; e1_re = 16'h0000;
`else
    e0_re = 16'hFFF0; e0_im = 16'h0008; e1_re = 16'h0007;
`endif
    for (int k = 0; k < 8; k++) begin xr[k] = '0; xi[k] = '0; end
    xr[0] = 16'hFFF0;
    xi[0] = 16'h0008;
    xr[4] = 16'h0007;
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_re !== e0_re || out_im !== e0_im) begin
      fails++; $display("FAIL scale_bin0: got re=%h im=%h want %h %h", out_re, out_im, e0_re, e0_im);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_idx !== 3'd1 || out_re !== e1_re) begin
      fails++; $display("FAIL scale_bin1: got idx=%0d re=%h want 1 %h", out_idx, out_re, e1_re);
    end
    for (int b = 1; b < 8; b++) tick();
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_full();
    test_streaming();
    test_reset_mid();
    test_scale();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/fft_unload.md
FFT_UNLOAD -- requirements
Module: fft_unload

Interface
REQ-001 SHALL have parameter N, default 4; sample width W = 2**N bits, two's complement.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports xr0..xr7  input  W each  real parts of final-stage butterfly outputs, bit-reversed order.
REQ-005 SHALL have ports xi0..xi7  input  W each  imaginary parts, same order.
REQ-006 SHALL have port in_valid  input  1  the 8 input pairs form a frame this cycle.
REQ-007 SHALL have port in_ready  output  1  a frame is accepted when in_valid and in_ready are both high.
REQ-008 SHALL have ports out_re, out_im  output  W each  current serial sample.
REQ-009 SHALL have port out_idx  output  3  natural-order bin index of the current sample.
REQ-010 SHALL have port out_last  output  1  high with bin 7.
REQ-011 SHALL have port out_valid  output  1  the serial sample is valid.
REQ-012 SHALL have port out_ready  input  1  the sink accepts the sample when out_valid and out_ready are both high.

Function
REQ-013 SHALL hold two banks (A, B); each bank holds 8 complex samples and one full flag.
REQ-014 SHALL keep a write-bank pointer and a read-bank pointer; both SHALL toggle A<->B only on a completed frame write or a completed frame read, respectively.
REQ-015 On accept, SHALL store input k at location k of the write bank, set that bank's full flag, and toggle the write pointer.
REQ-016 in_ready SHALL be a registered signal equal to NOT full(write bank).
REQ-017 out_valid SHALL equal full(read bank).
REQ-018 SHALL output location bitrev(cnt) of the read bank, where cnt is a 3-bit read counter and bitrev(b2b1b0) = b0b1b2; out_idx SHALL equal cnt.
REQ-019 On each out_valid and out_ready handshake, cnt SHALL increment.
REQ-020 On the handshake with cnt = 7, cnt SHALL wrap to 0, the read bank's full flag SHALL clear, and the read pointer SHALL toggle.
REQ-021 While out_valid is high and out_ready is low, out_re, out_im, out_idx and out_last SHALL hold stable.
REQ-022 Latency: for a frame accepted at edge T into an empty read bank, out_valid SHALL be high with bin 0 after T (one cycle).
REQ-023 Simultaneous accept into one bank and final read of the other bank SHALL both take effect in the same cycle, with no lost or duplicated frame.
REQ-024 With both banks full, in_ready SHALL be 0 and input data SHALL be ignored.
REQ-025 Sustained throughput SHALL be one sample per cycle; a new frame every 8 cycles SHALL never stall the input.

Reset
REQ-026 While rst = 0: in_ready = 0, out_valid = 0, out_last = 0, out_idx = 0, out_re = 0, out_im = 0, both full flags = 0, both pointers = A, cnt = 0.
REQ-027 in_ready SHALL rise on the first edge after rst deasserts.
REQ-028 Reset asserted mid-frame SHALL discard all buffered data; no partial frame SHALL be emitted after reset.

Configuration
REQ-029 With macro FFT_UNLOAD_SCALE_EN defined, out_re and out_im SHALL be the stored values arithmetically shifted right by 3 (sign-extended, truncating; divide by 8 for normalisation).
REQ-030 Without FFT_UNLOAD_SCALE_EN, samples SHALL pass unmodified.

Verification
REQ-031 Ordering: frame xr_k = 16'h0100+k, xi_k = -k, out_ready = 1 -> bins 0..7 carry xr = 0100, 0104, 0102, 0106, 0101, 0105, 0103, 0107; out_last is high on bin 7 only.
REQ-032 Back-pressure: frame as above, out_ready = 0 for 5 cycles at bin 3 -> out_re stays 16'h0106 with out_idx = 3; no sample is skipped.
REQ-033 Full: three frames offered back-to-back with out_ready = 0 -> frames 1 and 2 are accepted and in_ready = 0 for frame 3; after 8 reads in_ready = 1 the next cycle.
REQ-034 Streaming: a frame every 8 cycles with out_ready = 1 -> continuous out_valid, and no in_ready = 0 after the first frame.
REQ-035 Reset: rst pulled low at bin 4 -> all outputs 0; after release and a new frame, output starts at bin 0 of the new frame.
REQ-036 Scale (macro defined): xr0 = 16'hFFF0 (-16) -> bin 0 out_re = 16'hFFFE (-2); xr = 16'h0007 -> 16'h0000.
